seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode/cathode 7-segment display.
//  - Shares one external BCD-to-7-segment decoder across all digits.
//  - Each slot presents one digit's BCD code and enables one digit line.
//  - Inserts a dead-time gap between digits (anti-ghosting).
//  - Applies leading-zero and invalid-code blanking.
//  - Swaps new display values in tear-free at frame boundaries, via a valid/ready handshake.
// PARAMETERS
//  NUM_DIGITS   4      digits scanned; digit NUM_DIGITS-1 is most significant (>=1)
//  REFRESH_DIV  50000  clk cycles each digit is driven per slot (>=1)
//  DEAD_CYCLES  2      clk cycles all digits off between slots (>=0)
//  BLANK_LZ     1      1 = suppress leading zeros; digit 0 is never suppressed
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              synchronous reset, active-low
//  disp_en     in   1              1 = scan running; 0 = display off
//  upd_valid   in   1              new value offered
//  upd_value   in   4*NUM_DIGITS   packed BCD; digit k = upd_value[4k+3:4k]
//  upd_ready   out  1              controller can accept upd_value
//  bcd_digit   out  4              BCD code to the decoder (bit0 = LSB)
//  seg_blank   out  1              1 = force decoder segments off this cycle
//  dig_en      out  NUM_DIGITS     one-hot active-high digit enable; all-zero when off or in dead time
//  frame_done  out  1              1-cycle pulse at each frame wrap
// BEHAVIOUR
//  Outputs
//  - All outputs are registered: one cycle of latency from state to pins.
//  - Reset (rst_n=0 at a clk edge), applied even mid-scan:
//    state=OFF, idx=0, cnt=0, shadow=0, pending=0;
//    dig_en=0, bcd_digit=0, seg_blank=1, frame_done=0, upd_ready=1.
//  FSM states: OFF, DRIVE, DEAD
//  - OFF:   dig_en=0, seg_blank=1.
//           If a value is pending, commit it (shadow<=pending_val, pending<=0).
//           disp_en=1 -> DRIVE, idx=0, cnt=0.
//  - DRIVE: dig_en=1<<idx, bcd_digit=shadow[idx]. cnt increments each cycle.
//           At cnt==REFRESH_DIV-1: cnt<=0, go to DEAD.
//           If DEAD_CYCLES==0, advance idx directly and stay in DRIVE.
//  - DEAD:  dig_en=0, seg_blank=1. cnt increments each cycle.
//           At cnt==DEAD_CYCLES-1: cnt<=0, advance idx, go to DRIVE.
//  - Advancing idx:
//    - idx<NUM_DIGITS-1: idx<=idx+1.
//    - Otherwise (wrap): idx<=0, pulse frame_done, and commit any pending value.
//      The new value is first visible on digit 0 of the next frame.
//  - disp_en=0 in any state: next state OFF; dig_en=0 on the following cycle.
//    Re-enabling always restarts at idx=0 with a full slot.
//  - Frame period = NUM_DIGITS*(REFRESH_DIV+DEAD_CYCLES) cycles.
//  Blanking in DRIVE: seg_blank=1 when either holds:
//  - shadow[idx]>9 (invalid BCD); bcd_digit still shows the raw code.
//  - BLANK_LZ=1, idx>0, and shadow digits idx..NUM_DIGITS-1 are all zero.
//  Handshake
//  - upd_ready = !pending.
//  - Transfer on upd_valid&&upd_ready: pending_val<=upd_value, pending<=1.
//  - upd_value is ignored when upd_ready=0. upd_valid may drop without a transfer.
//  - Commit and accept never coincide: upd_ready rises the cycle after a commit.
//  Widths
//  - cnt is $clog2(max(REFRESH_DIV,DEAD_CYCLES,2)) bits.
//  - idx is $clog2(max(NUM_DIGITS,2)) bits.
//  - No counter exceeds its terminal value.
// STRUCTURE
//  Package seg_scan_pkg:
//  - scan_state_t enum {OFF, DRIVE, DEAD}.
//  - BCD_MAX=4'd9.
//  - Function lz_mask(value) returning a per-digit suppress vector.
//  Sub-module seg_slot_timer: the slot/dead-time cnt and its terminal-count flags.
//  FSM, handshake and blanking stay in the top module.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLANK_LZ=1 unless noted)
//  1. Reset: hold rst_n=0 with random inputs
//     -> dig_en=0, seg_blank=1, bcd_digit=0, frame_done=0, upd_ready=1.
//  2. Load 0x1234 while OFF, then disp_en=1
//     -> dig_en 0001 for 4 cycles with bcd=4, then 0000 for 1 cycle,
//        then 0010/bcd=3, 0100/bcd=2, 1000/bcd=1;
//     -> frame_done pulses once every 20 cycles.
//  3. Offer 0x5678 mid-frame
//     -> upd_ready=0 the next cycle; digits keep showing 1234 until wrap;
//     -> after frame_done, slot 0 shows bcd=8; upd_ready=1 the cycle after commit.
//  4. Value 0x0007
//     -> slots 3,2,1 seg_blank=1; slot 0 shows bcd=7 unblanked.
//     Value 0x0000 -> only slot 0 shows 0.
//     With BLANK_LZ=0, all slots unblanked.
//  5. Value 0x00A5
//     -> slot 1 bcd=A with seg_blank=1; slot 0 shows 5; slots 3,2 blanked.
//  6. Drop disp_en mid-DRIVE of slot 2 -> dig_en=0 the next cycle; re-enable -> restarts at slot 0.
//     Pulse rst_n=0 mid-DEAD -> reset values, and the pending value is discarded.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types, constants and the leading-zero helper for the 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } scan_state_t;

  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam int unsigned MAX_DIGITS = 16;

  // Per-digit suppress vector: bit k set when digits k..num_digits-1 are all zero (digit 0 never set).
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_DIGITS-1:0][3:0] value,
                                                    input int unsigned num_digits);
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int unsigned k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < num_digits) begin
        all_zero     = all_zero && (value[k[3:0]] == 4'd0);
        mask[k[3:0]] = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot / dead-time counter with terminal-count flags for the scan controller.
module seg_slot_timer #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_dead,
  output logic drive_tc_c,
  output logic dead_tc_c
);

  localparam logic [CNT_W-1:0] DRIVE_TERM = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_TERM  = CNT_W'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign drive_tc_c = (cnt == DRIVE_TERM);
  assign dead_tc_c  = (cnt == DEAD_TERM);

  // Count within the current phase; wrap to zero at the phase terminal or when cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (in_dead ? dead_tc_c : drive_tc_c)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with dead time, blanking and tear-free updates.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_en,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_value,
  output logic                    upd_ready,
  output logic [3:0]              bcd_digit,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX  = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int unsigned CNT_W    = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
  localparam int unsigned IDX_W    = $clog2((NUM_DIGITS > 2) ? NUM_DIGITS : 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t                     state, state_d;
  logic [IDX_W-1:0]                idx, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      shadow, pending_val;
  logic                            pending, pending_d;
  logic                            advance, wrap, commit, accept, active;
  logic                            drive_tc, dead_tc;
  logic [MAX_DIGITS-1:0][3:0]      shadow_ext;
  logic [MAX_DIGITS-1:0]           lz;
  logic [3:0]                      cur_digit;
  logic [NUM_DIGITS-1:0]           dig_en_d;
  logic [3:0]                      bcd_d;
  logic                            seg_blank_d;

  seg_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        ((state == OFF) || !disp_en),
    .in_dead    (state == DEAD),
    .drive_tc_c (drive_tc),
    .dead_tc_c  (dead_tc)
  );

  assign shadow_ext = (4*MAX_DIGITS)'(shadow);
  assign lz         = lz_mask(shadow_ext, NUM_DIGITS);
  assign accept     = upd_valid && upd_ready;

  // Next-state, slot index advance, frame wrap and pending-value commit.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    advance = 1'b0;
    wrap    = 1'b0;
    commit  = 1'b0;
    case (state)
      OFF: begin
        commit = pending;
        if (disp_en) begin
          state_d = DRIVE;
          idx_d   = '0;
        end
      end
      DRIVE: begin
        if (drive_tc) begin
          if (DEAD_CYCLES == 0) advance = 1'b1;
          else                  state_d = DEAD;
        end
      end
      DEAD: begin
        if (dead_tc) begin
          advance = 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = OFF;
    endcase
    if (advance) begin
      if (idx == LAST_IDX) begin
        idx_d  = '0;
        wrap   = 1'b1;
        commit = pending;
      end else begin
        idx_d = idx + IDX_W'(1);
      end
    end
    if (!disp_en) begin
      state_d = OFF;
      idx_d   = '0;
      wrap    = 1'b0;
      commit  = (state == OFF) && pending;
    end
  end

  // Pending flag and pin values derived from the current state.
  always_comb begin
    pending_d   = pending;
    if (commit)      pending_d = 1'b0;
    else if (accept) pending_d = 1'b1;
    active      = (state == DRIVE) && disp_en;
    cur_digit   = shadow[idx];
    dig_en_d    = active ? (NUM_DIGITS'(1) << idx) : '0;
    bcd_d       = active ? cur_digit : 4'd0;
    seg_blank_d = !active || (cur_digit > BCD_MAX) || ((BLANK_LZ != 0) && lz[idx]);
  end

  // FSM state, slot index and display value registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= OFF;
      idx         <= '0;
      pending     <= 1'b0;
      pending_val <= '0;
      shadow      <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      pending <= pending_d;
      if (accept) pending_val <= upd_value;
      if (commit) shadow      <= pending_val;
    end
  end

  // Registered output pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_en     <= '0;
      bcd_digit  <= 4'd0;
      seg_blank  <= 1'b1;
      frame_done <= 1'b0;
      upd_ready  <= 1'b1;
    end else begin
      dig_en     <= dig_en_d;
      bcd_digit  <= bcd_d;
      seg_blank  <= seg_blank_d;
      frame_done <= wrap;
      upd_ready  <= !pending_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (4 digits, 4-cycle slots, 1 dead cycle).
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        disp_en;
  logic        upd_valid;
  logic [15:0] upd_value;
  logic        upd_ready,  nl_upd_ready;
  logic [3:0]  bcd_digit,  nl_bcd_digit;
  logic        seg_blank,  nl_seg_blank;
  logic [3:0]  dig_en,     nl_dig_en;
  logic        frame_done, nl_frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .upd_valid(upd_valid), .upd_value(upd_value),
    .upd_ready(upd_ready), .bcd_digit(bcd_digit), .seg_blank(seg_blank), .dig_en(dig_en),
    .frame_done(frame_done)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLANK_LZ(0)) u_nolz (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .upd_valid(upd_valid), .upd_value(upd_value),
    .upd_ready(nl_upd_ready), .bcd_digit(nl_bcd_digit), .seg_blank(nl_seg_blank),
    .dig_en(nl_dig_en), .frame_done(nl_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check pin cycles first..last of a frame: cycle k is slot k/5, position k%5 (4 = dead).
  task automatic check_frame(input logic [15:0] val, input logic [3:0] blank,
                             input logic [3:0] nl_blank, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      int         slot;
      int         pos;
      logic [3:0] exp_en;
      logic [3:0] exp_bcd;
      logic       exp_fd;
      tick();
      slot    = k / 5;
      pos     = k % 5;
      exp_en  = (pos < 4) ? (4'b0001 << slot) : 4'b0000;
      exp_bcd = val[slot*4 +: 4];
      exp_fd  = (k == 19);
      checks++;
      if (dig_en !== exp_en || nl_dig_en !== exp_en) begin
        errors++;
        $display("FAIL frame_dig_en k=%0d val=%h: got %b/%b expected %b", k, val, dig_en, nl_dig_en, exp_en);
      end
      checks++;
      if (frame_done !== exp_fd || nl_frame_done !== exp_fd) begin
        errors++;
        $display("FAIL frame_done k=%0d: got %b/%b expected %b", k, frame_done, nl_frame_done, exp_fd);
      end
      if (pos < 4) begin
        checks++;
        if (bcd_digit !== exp_bcd || nl_bcd_digit !== exp_bcd) begin
          errors++;
          $display("FAIL frame_bcd k=%0d: got %h/%h expected %h", k, bcd_digit, nl_bcd_digit, exp_bcd);
        end
        checks++;
        if (seg_blank !== blank[slot]) begin
          errors++;
          $display("FAIL frame_blank k=%0d val=%h: got %b expected %b", k, val, seg_blank, blank[slot]);
        end
        checks++;
        if (nl_seg_blank !== nl_blank[slot]) begin
          errors++;
          $display("FAIL frame_blank_nolz k=%0d val=%h: got %b expected %b", k, val, nl_seg_blank, nl_blank[slot]);
        end
      end else begin
        checks++;
        if (seg_blank !== 1'b1 || nl_seg_blank !== 1'b1) begin
          errors++;
          $display("FAIL dead_blank k=%0d: got %b/%b expected 1", k, seg_blank, nl_seg_blank);
        end
      end
    end
  endtask

  // Offer a value right after a frame boundary; old value finishes the frame, new value shows next.
  task automatic load_and_show(input logic [15:0] prev, input logic [3:0] prev_blank,
                               input logic [3:0] prev_nl, input logic [15:0] val,
                               input logic [3:0] blank, input logic [3:0] nl_blank);
    upd_valid = 1'b1;
    upd_value = val;
    tick();
    upd_valid = 1'b0;
    checks++;
    if (dig_en !== 4'b0001 || bcd_digit !== prev[3:0]) begin
      errors++;
      $display("FAIL load_slot0: dig_en=%b bcd=%h expected 0001/%h", dig_en, bcd_digit, prev[3:0]);
    end
    check_frame(prev, prev_blank, prev_nl, 1, 19);
    check_frame(val, blank, nl_blank, 0, 19);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp_en   = 1'($urandom);
      upd_valid = 1'($urandom);
      upd_value = 16'($urandom);
      tick();
      checks++;
      if (dig_en !== 4'b0 || seg_blank !== 1'b1 || bcd_digit !== 4'd0 ||
          frame_done !== 1'b0 || upd_ready !== 1'b1 || nl_upd_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset: dig_en=%b blank=%b bcd=%h fd=%b ready=%b/%b expected 0000/1/0/0/1",
                 dig_en, seg_blank, bcd_digit, frame_done, upd_ready, nl_upd_ready);
      end
    end
    disp_en   = 1'b0;
    upd_valid = 1'b0;
    upd_value = 16'h0;
    rst_n     = 1'b1;
    tick();
    checks++;
    if (dig_en !== 4'b0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: dig_en=%b ready=%b expected 0000/1", dig_en, upd_ready);
    end
  endtask

  task automatic test_scan();
    upd_valid = 1'b1;
    upd_value = 16'h1234;
    tick();
    upd_valid = 1'b0;
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL off_accept_ready: got %b expected 0", upd_ready);
    end
    tick();
    checks++;
    if (upd_ready !== 1'b1 || dig_en !== 4'b0) begin
      errors++;
      $display("FAIL off_commit: ready=%b dig_en=%b expected 1/0000", upd_ready, dig_en);
    end
    disp_en = 1'b1;
    tick();
    checks++;
    if (dig_en !== 4'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL enable_latency: dig_en=%b fd=%b expected 0000/0", dig_en, frame_done);
    end
    check_frame(16'h1234, 4'b0000, 4'b0000, 0, 19);
    check_frame(16'h1234, 4'b0000, 4'b0000, 0, 19);
  endtask

  task automatic test_update();
    upd_valid = 1'b1;
    upd_value = 16'h5678;
    tick();
    checks++;
    if (upd_ready !== 1'b0 || dig_en !== 4'b0001 || bcd_digit !== 4'd4) begin
      errors++;
      $display("FAIL update_accept: ready=%b dig_en=%b bcd=%h expected 0/0001/4", upd_ready, dig_en, bcd_digit);
    end
    upd_value = 16'h9999;
    tick();
    upd_valid = 1'b0;
    checks++;
    if (upd_ready !== 1'b0 || bcd_digit !== 4'd4) begin
      errors++;
      $display("FAIL update_hold: ready=%b bcd=%h expected 0/4", upd_ready, bcd_digit);
    end
    check_frame(16'h1234, 4'b0000, 4'b0000, 2, 19);
    checks++;
    if (upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL update_ready_after_commit: got %b expected 1", upd_ready);
    end
    check_frame(16'h5678, 4'b0000, 4'b0000, 0, 19);
  endtask

  task automatic test_blanking();
    load_and_show(16'h5678, 4'b0000, 4'b0000, 16'h0007, 4'b1110, 4'b0000);
    load_and_show(16'h0007, 4'b1110, 4'b0000, 16'h0000, 4'b1110, 4'b0000);
  endtask

  task automatic test_invalid();
    load_and_show(16'h0000, 4'b1110, 4'b0000, 16'h00A5, 4'b1110, 4'b0010);
  endtask

  task automatic test_disable();
    check_frame(16'h00A5, 4'b1110, 4'b0010, 0, 11);
    disp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dig_en !== 4'b0 || seg_blank !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL disable_off c=%0d: dig_en=%b blank=%b fd=%b expected 0000/1/0", i, dig_en, seg_blank, frame_done);
      end
    end
    disp_en = 1'b1;
    tick();
    checks++;
    if (dig_en !== 4'b0) begin
      errors++;
      $display("FAIL reenable_latency: dig_en=%b expected 0000", dig_en);
    end
    check_frame(16'h00A5, 4'b1110, 4'b0010, 0, 19);
  endtask

  task automatic test_reset_mid_dead();
    upd_valid = 1'b1;
    upd_value = 16'h4321;
    tick();
    upd_valid = 1'b0;
    check_frame(16'h00A5, 4'b1110, 4'b0010, 1, 3);
    rst_n     = 1'b0;
    upd_valid = 1'b1;
    upd_value = 16'($urandom);
    tick();
    checks++;
    if (dig_en !== 4'b0 || seg_blank !== 1'b1 || bcd_digit !== 4'd0 ||
        frame_done !== 1'b0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_dead: dig_en=%b blank=%b bcd=%h fd=%b ready=%b expected 0000/1/0/0/1",
               dig_en, seg_blank, bcd_digit, frame_done, upd_ready);
    end
    rst_n     = 1'b1;
    upd_valid = 1'b0;
    disp_en   = 1'b1;
    tick();
    checks++;
    if (dig_en !== 4'b0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: dig_en=%b ready=%b expected 0000/1", dig_en, upd_ready);
    end
    check_frame(16'h0000, 4'b1110, 4'b0000, 0, 19);
  endtask

  initial begin
    rst_n     = 1'b0;
    disp_en   = 1'b0;
    upd_valid = 1'b0;
    upd_value = 16'h0;
    test_reset();
    test_scan();
    test_update();
    test_blanking();
    test_invalid();
    test_disable();
    test_reset_mid_dead();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
